// File: rtl/hls_fp17_mul_arb.sv
// Two-requester round-robin front end sharing one fp17 multiplier core.
// An in-order tag FIFO steers each core result back to the requester that issued it.
module hls_fp17_mul_arb #(
    parameter int TAG_DEPTH = 4
) (
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rstn,

    input  logic [16:0] req0_a,
    input  logic [16:0] req0_b,
    input  logic        req0_vld,
    output logic        req0_rdy,
    input  logic [16:0] req1_a,
    input  logic [16:0] req1_b,
    input  logic        req1_vld,
    output logic        req1_rdy,

    output logic [16:0] mul_a_z,
    output logic [16:0] mul_b_z,
    output logic        mul_in_vz,
    input  logic        mul_in_lz,
    input  logic [16:0] mul_o_z,
    input  logic        mul_o_lz,
    output logic        mul_o_vz,

    output logic [16:0] rsp0_z,
    output logic [16:0] rsp1_z,
    output logic        rsp0_vld,
    output logic        rsp1_vld,
    input  logic        rsp0_rdy,
    input  logic        rsp1_rdy,

    output logic [4:0]  outstanding,
    output logic        err
);

    localparam int         PW      = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(TAG_DEPTH);

    logic [TAG_DEPTH-1:0] r_tag;
    logic [PW-1:0]        r_wptr;
    logic [PW-1:0]        r_rptr;
    logic [4:0]           r_count;
    logic                 r_rr;
    logic                 r_err;

    logic w_any;
    logic w_full;
    logic w_empty;
    logic w_win;
    logic w_issue;
    logic w_head;
    logic w_head_rdy;
    logic w_retire;

    assign w_any   = req0_vld | req1_vld;
    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == 5'd0);

    // Under contention the requester that did not win last issue goes next.
    assign w_win = (req0_vld & req1_vld) ? ~r_rr : req1_vld;

    assign mul_a_z   = w_any ? (w_win ? req1_a : req0_a) : 17'd0;
    assign mul_b_z   = w_any ? (w_win ? req1_b : req0_b) : 17'd0;
    assign mul_in_vz = w_any & ~w_full;
    assign req0_rdy  = ~w_win & mul_in_lz & ~w_full;
    assign req1_rdy  =  w_win & mul_in_lz & ~w_full;
    assign w_issue   = mul_in_vz & mul_in_lz;

    assign w_head     = r_tag[r_rptr];
    assign w_head_rdy = w_head ? rsp1_rdy : rsp0_rdy;
    assign mul_o_vz   = ~w_empty & w_head_rdy;
    assign w_retire   = mul_o_lz & mul_o_vz;

    assign rsp0_z   = mul_o_z;
    assign rsp1_z   = mul_o_z;
    assign rsp0_vld = mul_o_lz & ~w_empty & ~w_head;
    assign rsp1_vld = mul_o_lz & ~w_empty &  w_head;

    assign outstanding = r_count;
    assign err         = r_err;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_tag   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= 5'd0;
            r_rr    <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            if (w_issue) begin
                r_tag[r_wptr] <= w_win;
                r_wptr        <= r_wptr + PW'(1);
                r_rr          <= w_win;
            end
            if (w_retire) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_issue, w_retire})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
            // A result with nothing outstanding means the core and the tag FIFO disagree.
            if (mul_o_lz & w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hls_fp17_mul_arb.sv
// Bench for hls_fp17_mul_arb: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of outstanding operations.
module tb_hls_fp17_mul_arb;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [16:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_vld = 1'b0, req1_vld = 1'b0;
    logic        req0_rdy, req1_rdy;
    logic [16:0] mul_a_z, mul_b_z;
    logic        mul_in_vz;
    logic        mul_in_lz = 1'b0;
    logic [16:0] mul_o_z = '0;
    logic        mul_o_lz = 1'b0;
    logic        mul_o_vz;
    logic [16:0] rsp0_z, rsp1_z;
    logic        rsp0_vld, rsp1_vld;
    logic        rsp0_rdy = 1'b0, rsp1_rdy = 1'b0;
    logic [4:0]  outstanding;
    logic        err;

    hls_fp17_mul_arb #(.TAG_DEPTH(DEPTH)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rstn),
        .req0_a(req0_a), .req0_b(req0_b), .req0_vld(req0_vld), .req0_rdy(req0_rdy),
        .req1_a(req1_a), .req1_b(req1_b), .req1_vld(req1_vld), .req1_rdy(req1_rdy),
        .mul_a_z(mul_a_z), .mul_b_z(mul_b_z), .mul_in_vz(mul_in_vz), .mul_in_lz(mul_in_lz),
        .mul_o_z(mul_o_z), .mul_o_lz(mul_o_lz), .mul_o_vz(mul_o_vz),
        .rsp0_z(rsp0_z), .rsp1_z(rsp1_z), .rsp0_vld(rsp0_vld), .rsp1_vld(rsp1_vld),
        .rsp0_rdy(rsp0_rdy), .rsp1_rdy(rsp1_rdy),
        .outstanding(outstanding), .err(err)
    );

    always #5 clk = ~clk;

    // Operations in flight inside the core, oldest first.
    typedef struct packed {
        logic        id;
        logic [16:0] val;
    } op_t;

    op_t q[$];
    bit  m_rr  = 1'b1;
    bit  m_err = 1'b0;
    bit  e_issue, e_retire, e_win, e_err_set, e_rdy0, e_rdy1;
    int  n_pass = 0;
    int  n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        else
            n_pass++;
    endtask

    function automatic logic [16:0] result_of(input logic [16:0] a, input logic [16:0] b);
        return a + {b[7:0], b[16:8]};
    endfunction

    task automatic drive_core();
        mul_o_z = (q.size() != 0) ? q[0].val : 17'($urandom);
    endtask

    // Compare every DUT output with the model, mid-cycle.
    task automatic eval();
        bit          any, full, empty, head, hrdy, vz, ovz;
        logic [16:0] ea, eb;
        #3;
        any   = req0_vld | req1_vld;
        full  = (q.size() == DEPTH);
        empty = (q.size() == 0);
        e_win = (req0_vld && req1_vld) ? !m_rr : req1_vld;
        ea    = !any ? 17'd0 : (e_win ? req1_a : req0_a);
        eb    = !any ? 17'd0 : (e_win ? req1_b : req0_b);
        vz    = any && !full;
        e_rdy0 = !e_win && mul_in_lz && !full;
        e_rdy1 =  e_win && mul_in_lz && !full;
        head  = empty ? 1'b0 : q[0].id;
        hrdy  = head ? rsp1_rdy : rsp0_rdy;
        ovz   = !empty && hrdy;
        chk("mul_a_z", 32'(mul_a_z), 32'(ea));
        chk("mul_b_z", 32'(mul_b_z), 32'(eb));
        chk("mul_in_vz", 32'(mul_in_vz), 32'(vz));
        chk("req0_rdy", 32'(req0_rdy), 32'(e_rdy0));
        chk("req1_rdy", 32'(req1_rdy), 32'(e_rdy1));
        chk("mul_o_vz", 32'(mul_o_vz), 32'(ovz));
        chk("rsp0_vld", 32'(rsp0_vld), 32'(mul_o_lz && !empty && head == 1'b0));
        chk("rsp1_vld", 32'(rsp1_vld), 32'(mul_o_lz && !empty && head == 1'b1));
        chk("rsp0_z", 32'(rsp0_z), 32'(mul_o_z));
        chk("rsp1_z", 32'(rsp1_z), 32'(mul_o_z));
        chk("outstanding", 32'(outstanding), 32'(q.size()));
        chk("err", 32'(err), 32'(m_err));
        e_issue   = vz && mul_in_lz;
        e_retire  = mul_o_lz && ovz;
        e_err_set = mul_o_lz && empty;
    endtask

    task automatic adv();
        op_t o;
        if (e_retire) void'(q.pop_front());
        if (e_issue) begin
            o.id  = e_win;
            o.val = e_win ? result_of(req1_a, req1_b) : result_of(req0_a, req0_b);
            q.push_back(o);
            m_rr = e_win;
        end
        if (e_err_set) m_err = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        eval();
        adv();
    endtask

    task automatic idle_inputs();
        req0_vld = 1'b0; req1_vld = 1'b0; mul_in_lz = 1'b0;
        mul_o_lz = 1'b0; rsp0_rdy = 1'b0; rsp1_rdy = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_mul_o_vz", 32'(mul_o_vz), 32'd0);
        chk("rst_rsp_vld", 32'({rsp0_vld, rsp1_vld}), 32'd0);
        q.delete();
        m_rr  = 1'b1;
        m_err = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic rand_cycle();
        if (!(req0_vld && !e_rdy0)) begin
            req0_vld = ($urandom_range(3) != 0);
            req0_a = 17'($urandom); req0_b = 17'($urandom);
        end
        if (!(req1_vld && !e_rdy1)) begin
            req1_vld = ($urandom_range(3) != 0);
            req1_a = 17'($urandom); req1_b = 17'($urandom);
        end
        mul_in_lz = ($urandom_range(3) != 0);
        mul_o_lz  = (q.size() != 0) && ($urandom_range(2) != 0);
        rsp0_rdy  = ($urandom_range(3) != 0);
        rsp1_rdy  = ($urandom_range(3) != 0);
        drive_core();
        step();
    endtask

    initial begin
        bit g[4];
        g = '{1'b0, 1'b1, 1'b0, 1'b1};
        #2;
        chk("init_outstanding", 32'(outstanding), 32'd0);
        chk("init_mul_o_vz", 32'(mul_o_vz), 32'd0);
        chk("init_rsp_vld", 32'({rsp0_vld, rsp1_vld}), 32'd0);
        chk("init_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Solo traffic
        req0_vld = 1'b1; req0_a = 17'h0F800; req0_b = 17'h0F800; mul_in_lz = 1'b1;
        eval();
        chk("solo_req0_rdy", 32'(req0_rdy), 32'd1);
        chk("solo_mul_a", 32'(mul_a_z), 32'h0F800);
        adv();
        chk("solo_out1", 32'(outstanding), 32'd1);
        req0_vld = 1'b0; mul_o_lz = 1'b1; rsp0_rdy = 1'b1; mul_o_z = 17'h0F800;
        eval();
        chk("solo_rsp0_vld", 32'(rsp0_vld), 32'd1);
        chk("solo_rsp1_vld", 32'(rsp1_vld), 32'd0);
        chk("solo_rsp0_z", 32'(rsp0_z), 32'h0F800);
        adv();
        chk("solo_out0", 32'(outstanding), 32'd0);

        // Contention from reset: 0,1,0,1 then full
        do_reset();
        req0_vld = 1'b1; req0_a = 17'h00101; req0_b = 17'h00202;
        req1_vld = 1'b1; req1_a = 17'h10303; req1_b = 17'h10404;
        mul_in_lz = 1'b1;
        for (int i = 0; i < 4; i++) begin
            eval();
            chk("grant_r1", 32'(req1_rdy), 32'(g[i]));
            chk("grant_r0", 32'(req0_rdy), 32'(!g[i]));
            adv();
        end
        chk("full_out", 32'(outstanding), 32'd4);
        eval();
        chk("full_vz", 32'(mul_in_vz), 32'd0);
        chk("full_rdy", 32'({req0_rdy, req1_rdy}), 32'd0);
        adv();
        mul_o_lz = 1'b1; rsp0_rdy = 1'b1; rsp1_rdy = 1'b1; drive_core();
        eval();
        chk("full_ret_rsp0", 32'(rsp0_vld), 32'd1);
        chk("full_ret_vz", 32'(mul_in_vz), 32'd0);
        adv();
        chk("full_out3", 32'(outstanding), 32'd3);

        // Backpressure on head tag 1, requester 0 still issues
        req1_vld = 1'b0; rsp1_rdy = 1'b0; drive_core();
        eval();
        chk("bp_o_vz", 32'(mul_o_vz), 32'd0);
        chk("bp_rsp1_vld", 32'(rsp1_vld), 32'd1);
        chk("bp_req0_rdy", 32'(req0_rdy), 32'd1);
        adv();
        chk("bp_out4", 32'(outstanding), 32'd4);
        req0_vld = 1'b0;
        eval();
        chk("bp_rsp1_hold", 32'(rsp1_vld), 32'd1);
        adv();
        chk("bp_out_hold", 32'(outstanding), 32'd4);

        rsp0_rdy = 1'b1; rsp1_rdy = 1'b1;
        for (int k = 0; k < 20 && q.size() != 0; k++) begin
            drive_core();
            step();
        end
        chk("drain_out", 32'(outstanding), 32'd0);

        // Simultaneous issue and retire at 2, across pointer wrap
        mul_o_lz = 1'b0; req0_vld = 1'b1; req1_vld = 1'b1;
        step();
        step();
        chk("sim_fill", 32'(outstanding), 32'd2);
        mul_o_lz = 1'b1;
        for (int k = 0; k < 7; k++) begin
            drive_core();
            req0_a = 17'($urandom); req1_a = 17'($urandom);
            step();
            chk("sim_out2", 32'(outstanding), 32'd2);
        end
        req0_vld = 1'b0; req1_vld = 1'b0;
        for (int k = 0; k < 20 && q.size() != 0; k++) begin
            drive_core();
            step();
        end

        // Result with nothing outstanding
        mul_o_lz = 1'b1; mul_o_z = 17'h1234;
        eval();
        chk("err_o_vz", 32'(mul_o_vz), 32'd0);
        adv();
        chk("err_set", 32'(err), 32'd1);
        mul_o_lz = 1'b0;
        step();
        step();
        chk("err_sticky", 32'(err), 32'd1);

        // Random traffic, then reset mid-stream, then more random traffic
        for (int k = 0; k < 300; k++) rand_cycle();
        do_reset();
        req0_vld = 1'b1; req1_vld = 1'b1; mul_in_lz = 1'b1;
        eval();
        chk("rr_after_rst", 32'(req0_rdy), 32'd1);
        adv();
        for (int k = 0; k < 2000; k++) rand_cycle();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
